// File: rtl/apb_master_ctrl_pkg.sv
// Shared types and constants for the multi-requester APB master controller.
// Optional timeout abort is enabled with the APB_TIMEOUT_EN macro.
package apb_ctrl_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;
   localparam int MAX_REQ    = 4;
   localparam int IDX_W      = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

endpackage

// File: rtl/apb_master_ctrl_if.sv
// APB bus bundle between the controller (master) and the decoder/slave side.
interface apb_master_ctrl_if
   import apb_ctrl_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);

   logic              PSEL;
   logic              PENABLE;
   logic [ADDR_W-1:0] PADDR;
   logic              PWRITE;
   logic [DATA_W-1:0] PWDATA;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;
   logic              PSLVERR;

   modport master (
      output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );

endinterface

// File: rtl/apb_master_ctrl_arbiter.sv
// Combinational round-robin arbiter: searches upward from last_grant+1, wrapping modulo NUM_REQ.
module apb_rr_arbiter
   import apb_ctrl_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               any_req
);

   logic [MAX_REQ-1:0] req_pad_s;
   logic [IDX_W-1:0]   idx_s;

   assign req_pad_s = MAX_REQ'(req);
   assign any_req   = |req;
   assign grant_idx = idx_s;

   // Walk offsets from farthest to nearest so the nearest requester wins.
   always_comb begin
      idx_s = '0;
      for (int off = NUM_REQ; off >= 1; off--) begin
         logic [IDX_W-1:0] cand_v;
         cand_v = IDX_W'((int'(last_grant) + off) % NUM_REQ);
         if (req_pad_s[cand_v]) begin
            idx_s = cand_v;
         end else begin
            idx_s = idx_s;
         end
      end
   end

   // Expand the winning index into a one-hot grant.
   always_comb begin
      grant = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         grant[i] = any_req && (idx_s == IDX_W'(i));
      end
   end

endmodule

// File: rtl/apb_master_ctrl.sv
// Multi-requester APB master: round-robin arbitration, IDLE/SETUP/ACCESS sequencing, response return.
// Define APB_TIMEOUT_EN to abort ACCESS phases that exceed TIMEOUT_CYCLES without PREADY.
module apb_master_ctrl
   import apb_ctrl_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                      PCLK,
   input  logic                      PRESETn,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_err,
   apb_master_ctrl_if.master         apb
);

   apb_state_e         state_r, state_s;
   logic [IDX_W-1:0]   last_grant_r, last_grant_s;
   logic [IDX_W-1:0]   gidx_r, gidx_s;
   logic [NUM_REQ-1:0] req_ready_r, req_ready_s;
   logic [NUM_REQ-1:0] rsp_valid_r, rsp_valid_s;
   logic [DATA_W-1:0]  rsp_rdata_r, rsp_rdata_s;
   logic               rsp_err_r, rsp_err_s;
   logic               psel_r, psel_s;
   logic               penable_r, penable_s;
   logic [ADDR_W-1:0]  paddr_r, paddr_s;
   logic               pwrite_r, pwrite_s;
   logic [DATA_W-1:0]  pwdata_r, pwdata_s;
`ifdef APB_TIMEOUT_EN
   logic [7:0]         cnt_r, cnt_s;
`endif

   logic [NUM_REQ-1:0] grant_s;
   logic [IDX_W-1:0]   grant_idx_s;
   logic               any_req_s;
   logic [MAX_REQ-1:0] valid_pad_s;
   logic [ADDR_W-1:0]  sel_addr_s;
   logic [DATA_W-1:0]  sel_wdata_s;
   logic               sel_write_s;
   logic [NUM_REQ-1:0] owner_oh_s;

   apb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req        (req_valid),
      .last_grant (last_grant_r),
      .grant      (grant_s),
      .grant_idx  (grant_idx_s),
      .any_req    (any_req_s)
   );

   assign valid_pad_s = MAX_REQ'(req_valid);

   // Select the payload of the requester currently holding req_ready.
   always_comb begin
      sel_addr_s  = '0;
      sel_wdata_s = '0;
      sel_write_s = 1'b0;
      owner_oh_s  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         owner_oh_s[i] = (gidx_r == IDX_W'(i));
         if (gidx_r == IDX_W'(i)) begin
            sel_addr_s  = req_addr[i*ADDR_W +: ADDR_W];
            sel_wdata_s = req_wdata[i*DATA_W +: DATA_W];
            sel_write_s = req_write[i];
         end else begin
            sel_write_s = sel_write_s;
         end
      end
   end

   // Next-state and next-output logic for the transfer sequencer.
   always_comb begin
      state_s      = state_r;
      last_grant_s = last_grant_r;
      gidx_s       = gidx_r;
      req_ready_s  = '0;
      rsp_valid_s  = '0;
      rsp_rdata_s  = rsp_rdata_r;
      rsp_err_s    = rsp_err_r;
      psel_s       = psel_r;
      penable_s    = penable_r;
      paddr_s      = paddr_r;
      pwrite_s     = pwrite_r;
      pwdata_s     = pwdata_r;
`ifdef APB_TIMEOUT_EN
      cnt_s        = cnt_r;
`endif
      case (state_r)
         IDLE: begin
            // A granted requester that withdrew its valid simply loses the slot.
            if (req_ready_r != '0) begin
               if (valid_pad_s[gidx_r]) begin
                  paddr_s      = sel_addr_s;
                  pwdata_s     = sel_wdata_s;
                  pwrite_s     = sel_write_s;
                  psel_s       = 1'b1;
                  last_grant_s = gidx_r;
                  state_s      = SETUP;
               end else begin
                  state_s = IDLE;
               end
            end else if (any_req_s) begin
               req_ready_s = grant_s;
               gidx_s      = grant_idx_s;
            end else begin
               state_s = IDLE;
            end
         end
         SETUP: begin
            penable_s = 1'b1;
            state_s   = ACCESS;
`ifdef APB_TIMEOUT_EN
            cnt_s     = 8'd0;
`endif
         end
         ACCESS: begin
            if (apb.PREADY) begin
               psel_s      = 1'b0;
               penable_s   = 1'b0;
               rsp_valid_s = owner_oh_s;
               rsp_err_s   = apb.PSLVERR;
               rsp_rdata_s = pwrite_r ? {DATA_W{1'b0}} : apb.PRDATA;
               state_s     = IDLE;
            end else begin
`ifdef APB_TIMEOUT_EN
               if (cnt_r == 8'(TIMEOUT_CYCLES - 1)) begin
                  psel_s      = 1'b0;
                  penable_s   = 1'b0;
                  rsp_valid_s = owner_oh_s;
                  rsp_err_s   = 1'b1;
                  rsp_rdata_s = {DATA_W{1'b0}};
                  state_s     = IDLE;
               end else begin
                  cnt_s = cnt_r + 8'd1;
               end
`else
               state_s = ACCESS;
`endif
            end
         end
         default: begin
            psel_s    = 1'b0;
            penable_s = 1'b0;
            state_s   = IDLE;
         end
      endcase
   end

   // State and registered-output flops; reset drops the bus immediately.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_r      <= IDLE;
         last_grant_r <= IDX_W'(NUM_REQ - 1);
         gidx_r       <= '0;
         req_ready_r  <= '0;
         rsp_valid_r  <= '0;
         rsp_rdata_r  <= '0;
         rsp_err_r    <= 1'b0;
         psel_r       <= 1'b0;
         penable_r    <= 1'b0;
         paddr_r      <= '0;
         pwrite_r     <= 1'b0;
         pwdata_r     <= '0;
`ifdef APB_TIMEOUT_EN
         cnt_r        <= 8'd0;
`endif
      end else begin
         state_r      <= state_s;
         last_grant_r <= last_grant_s;
         gidx_r       <= gidx_s;
         req_ready_r  <= req_ready_s;
         rsp_valid_r  <= rsp_valid_s;
         rsp_rdata_r  <= rsp_rdata_s;
         rsp_err_r    <= rsp_err_s;
         psel_r       <= psel_s;
         penable_r    <= penable_s;
         paddr_r      <= paddr_s;
         pwrite_r     <= pwrite_s;
         pwdata_r     <= pwdata_s;
`ifdef APB_TIMEOUT_EN
         cnt_r        <= cnt_s;
`endif
      end
   end

   assign req_ready   = req_ready_r;
   assign rsp_valid   = rsp_valid_r;
   assign rsp_rdata   = rsp_rdata_r;
   assign rsp_err     = rsp_err_r;
   assign apb.PSEL    = psel_r;
   assign apb.PENABLE = penable_r;
   assign apb.PADDR   = paddr_r;
   assign apb.PWRITE  = pwrite_r;
   assign apb.PWDATA  = pwdata_r;

endmodule
